// File: rtl/upe_mul16uu_core.sv
// ---------------------------------------------------------------------------
// upe_mul16uu_core
//   Unsigned x unsigned integer multiplier, WIDTH x WIDTH -> 2*WIDTH, with a
//   valid qualifier. This is the arithmetic core of the UPE datapath. It
//   accepts one operand pair per cycle and returns the exact full-width
//   product, in order, with no stalls.
//
//   Structure
//     Stage 1 splits B into a low half and a high half. It forms two partial
//     products, PL = A*B_lo and PH = A*B_hi, each WIDTH+WIDTH/2 bits wide.
//     Stage 2 combines them as Out = PL + (PH << WIDTH/2) into the output
//     register.
//
//   Configuration macro: UPE_MUL16_PIPE_EN
//     defined   : PL, PH and their valid bit are registered between the two
//                 stages. The latency is 2 edges.
//     undefined : both stages form one combinational cone into the output
//                 register. The latency is 1 edge.
//     The results are the same in both builds. Only the latency differs.
//
//   Parameters
//     WIDTH      operand width (even, >= 4), default 16
//
//   Ports
//     clk        single clock, rising edge
//     rst        asynchronous, active-high reset
//     in_valid   A/B carry a new operand pair this cycle
//     A, B       unsigned operands, WIDTH bits each
//     out_valid  one-cycle pulse per result
//     Out        product A*B, 2*WIDTH bits; holds the last product while
//                out_valid=0
// ---------------------------------------------------------------------------
module upe_mul16uu_core #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] Out
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = WIDTH + HALF;   // partial-product width
  localparam int OW   = 2 * WIDTH;      // product width

  // part[0] = A * B_lo, part[1] = A * B_hi
  logic [1:0][PW-1:0] part;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_part
      assign part[gi] = PW'(A) * PW'(B[gi*HALF +: HALF]);
    end
  endgenerate

  // Operands of stage 2, either registered or taken straight from stage 1
  logic [PW-1:0] s2_pl;
  logic [PW-1:0] s2_ph;
  logic          s2_valid;

`ifdef UPE_MUL16_PIPE_EN
  logic [PW-1:0] pl_reg;
  logic [PW-1:0] ph_reg;
  logic          s1_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_reg       <= '0;
      ph_reg       <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      // Capture only real operands; bubbles leave the partials untouched
      if (in_valid) begin
        pl_reg <= part[0];
        ph_reg <= part[1];
      end
    end
  end

  assign s2_pl    = pl_reg;
  assign s2_ph    = ph_reg;
  assign s2_valid = s1_valid_reg;
`else
  assign s2_pl    = part[0];
  assign s2_ph    = part[1];
  assign s2_valid = in_valid;
`endif

  // Stage 2: realign the high partial product by half a word and add
  logic [OW-1:0] sum_next;
  assign sum_next = OW'(s2_pl) + (OW'(s2_ph) << HALF);

  logic [OW-1:0] out_reg;
  logic          out_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= s2_valid;
      // Out is held between results so slow consumers can sample any time
      if (s2_valid) begin
        out_reg <= sum_next;
      end
    end
  end

  assign Out       = out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_upe_mul16uu_core.sv
// ---------------------------------------------------------------------------
// tb_upe_mul16uu_core
//   Self-checking bench for upe_mul16uu_core. The bench keeps a reference
//   model of the design. The model takes each operand pair sampled on a
//   clock edge and delivers its product A*B exactly L edges later. It holds
//   the last product between results. A reset discards everything in flight.
//   A compare process checks the DUT against this model on every falling
//   edge. A few literal products pin the model itself. Define
//   UPE_MUL16_PIPE_EN to check the pipelined build (L=2).
// ---------------------------------------------------------------------------
module tb_upe_mul16uu_core;

`ifdef UPE_MUL16_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] A;
  logic [15:0] B;
  logic        out_valid;
  logic [31:0] Out;

  upe_mul16uu_core #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .Out      (Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  bit cmp_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] x;
    logic [31:0] y;
    x = {16'h0, a};
    y = {16'h0, b};
    return x * y;
  endfunction

  // Reference model. The queue holds L-1 entries, so the entry popped on
  // an edge is the operand pair sampled L-1 edges earlier. That pair then
  // shows on the outputs just after this edge, which is L edges after it
  // was sampled.
  typedef struct {
    bit          v;
    logic [31:0] p;
  } item_t;

  item_t       pipe_q[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_out   = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q.delete();
      for (int i = 0; i < L - 1; i++) pipe_q.push_back('{1'b0, 32'h0});
      exp_valid <= 1'b0;
      exp_out   <= 32'h0;
    end else begin
      pipe_q.push_back('{in_valid, ref_mul(A, B)});
      exp_valid <= pipe_q[0].v;
      if (pipe_q[0].v) exp_out <= pipe_q[0].p;
      void'(pipe_q.pop_front());
    end
  end

  // Cycle-by-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check1("out_valid", out_valid, exp_valid);
      check32("Out", Out, exp_out);
    end
    if (out_valid === 1'b1) n_out++;
  end

  // One pulsed operand pair. Checks the pulse, its value and the hold.
  task automatic apply_one(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom);
    repeat (L - 1) @(negedge clk);
    check1("pulse_valid", out_valid, 1'b1);
    check32("pulse_out", Out, exp);
    @(negedge clk);
    check1("pulse_drop", out_valid, 1'b0);
    check32("pulse_hold", Out, exp);
  endtask

  int base_out;

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = 16'h0; B = 16'h0;
    cmp_en = 1'b1;

    // Pin the reference model with hand-computed products
    check32("ref_3953x5acd", ref_mul(16'h3953, 16'h5ACD), 32'h14551577);
    check32("ref_ffffxffff", ref_mul(16'hFFFF, 16'hFFFF), 32'hFFFE0001);
    check32("ref_0000xbeef", ref_mul(16'h0000, 16'hBEEF), 32'h00000000);

    // Reset held with the inputs toggling at random
    repeat (20) begin
      @(negedge clk);
      check32("rst_out", Out, 32'h0);
      check1("rst_valid", out_valid, 1'b0);
      in_valid = 1'($urandom); A = 16'($urandom); B = 16'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Directed products
    apply_one(16'h0003, 16'h0003, 32'h00000009);
    apply_one(16'h3953, 16'h5ACD, 32'h14551577);
    apply_one(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    apply_one(16'h0000, 16'hBEEF, 32'h00000000);
    apply_one(16'h00FF, 16'h0100, 32'h0000FF00);

    // Back-to-back stream of 1000 random pairs
    @(negedge clk);
    base_out = n_out;
    repeat (1000) begin
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (L + 2) @(negedge clk);
    check32("stream_count", 32'(n_out - base_out), 32'd1000);

    // Random mix of bubbles and operands
    repeat (300) begin
      in_valid = 1'($urandom); A = 16'($urandom); B = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (L + 2) @(negedge clk);

    // Asynchronous reset between edges with products in flight
    repeat (3) begin
      in_valid = 1'b1; A = 16'($urandom_range(256, 65535)); B = 16'($urandom_range(256, 65535));
      @(negedge clk);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check32("async_rst_out", Out, 32'h0);
    check1("async_rst_valid", out_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    base_out = n_out;
    repeat (L + 3) @(negedge clk);
    check32("post_rst_out", Out, 32'h0);
    check32("post_rst_count", 32'(n_out - base_out), 32'd0);

    // Normal operation after reset
    apply_one(16'h1234, 16'h5678, 32'h06260060);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
